// File: rtl/cmac_vector_sequencer.sv
// Control stage in front of the complex multiply-accumulate unit: issues one unit step per
// accepted operand pair and captures one dot product per vector into a single-entry result slot.
module cmac_vector_sequencer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [31:0]      in_bias,
  input  logic [LEN_W-1:0] in_len_m1,
  output logic [31:0]      mac_x,
  output logic [31:0]      mac_y,
  output logic [31:0]      mac_accum,
  output logic             mac_is_load,
  output logic             mac_enable,
  input  logic [31:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_m1;
  logic             r_cap_pending;
  logic             r_res_valid;
  logic [31:0]      r_res_data;

  logic             w_is_last;
  logic             w_accept;

  assign w_is_last = ((r_state == StIdle) && (in_len_m1 == '0)) ||
                     ((r_state == StRun) && (r_cnt == r_len_m1));

  // Only the closing term waits: it must find the result slot free when its capture lands.
  assign in_ready = !w_is_last || (!r_cap_pending && (!r_res_valid || res_ready));
  assign w_accept = in_valid && in_ready;

  assign mac_x       = in_x;
  assign mac_y       = in_y;
  assign mac_accum   = in_bias;
  assign mac_enable  = w_accept;
  assign mac_is_load = w_accept && (r_state == StIdle);

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = (r_state == StRun) || r_cap_pending || r_res_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_len_m1      <= '0;
      r_cap_pending <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
    end else begin
      r_cap_pending <= w_accept && w_is_last;

      if (w_accept) begin
        case (r_state)
          StIdle: begin
            r_len_m1 <= in_len_m1;
            if (!w_is_last) begin
              r_state <= StRun;
              r_cnt   <= LEN_W'(1);
            end
          end
          StRun: begin
            if (w_is_last) begin
              r_state <= StIdle;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + LEN_W'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end

      // The unit's output is final one cycle after the last step; a capture beats a pop.
      if (r_cap_pending) begin
        r_res_data  <= mac_result;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmac_vector_sequencer.sv
// Bench for cmac_vector_sequencer: a behavioural complex MAC unit closes the loop and a
// scoreboard compares each emitted dot product against one computed from the driven terms.
module tb_cmac_vector_sequencer;

  localparam int unsigned LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x, in_y, in_bias;
  logic [LEN_W-1:0] in_len_m1;
  logic [31:0]      mac_x, mac_y, mac_accum;
  logic             mac_is_load, mac_enable;
  logic [31:0]      mac_result;
  logic             res_valid, res_ready;
  logic [31:0]      res_data;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  bit          ld_q[$];
  int          en_cnt    = 0;
  int          stall_bad = 0;
  logic [31:0] m_acc;

  cmac_vector_sequencer #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_bias(in_bias), .in_len_m1(in_len_m1),
    .mac_x(mac_x), .mac_y(mac_y), .mac_accum(mac_accum),
    .mac_is_load(mac_is_load), .mac_enable(mac_enable), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] re, im;
    re = a[31:16] * b[31:16] - a[15:0] * b[15:0];
    im = a[31:16] * b[15:0] + a[15:0] * b[31:16];
    return {re, im};
  endfunction

  function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] re, im;
    re = a[31:16] + b[31:16];
    im = a[15:0] + b[15:0];
    return {re, im};
  endfunction

  // Behavioural multiplyAdder: registered mulAdd, loaded from accum on is_load.
  always @(posedge CLK) begin
    if (mac_enable) m_acc <= cadd(mac_is_load ? mac_accum : m_acc, cmul(mac_x, mac_y));
  end
  assign mac_result = m_acc;

  always @(negedge CLK) begin
    if (res_valid && res_ready) obs_q.push_back(res_data);
    if (mac_enable) begin
      ld_q.push_back(mac_is_load);
      en_cnt = en_cnt + 1;
      if (!in_valid) stall_bad = stall_bad + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // Offers one term; returns the number of cycles in_ready was low (-1 on timeout).
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] b,
                      input logic [LEN_W-1:0] l, input bit hold, output int waits);
    in_x = x; in_y = y; in_bias = b; in_len_m1 = l; in_valid = 1'b1;
    waits = -1;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (in_ready) begin
        @(posedge CLK); #1;
        waits = c;
        break;
      end
      @(posedge CLK); #1;
    end
    if (!hold || waits < 0) in_valid = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    in_x = '0; in_y = '0; in_bias = '0; in_len_m1 = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_total++; if (res_data !== 32'h0) $display("FAIL reset_res_data: got %h want 0", res_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (mac_enable !== 1'b0) $display("FAIL reset_mac_enable: got %b want 0", mac_enable); else n_pass++;
    n_total++; if (mac_is_load !== 1'b0) $display("FAIL reset_is_load: got %b want 0", mac_is_load); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    #4 RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_vector;
    int w0, w1, w2;
    logic [31:0] e;
    ld_q.delete();
    e = 32'h0001_0002;
    send(32'h0001_0000, 32'h0001_0000, 32'h0001_0002, 8'd2, 1'b0, w0);
    e = cadd(e, cmul(32'h0001_0000, 32'h0001_0000));
    // bias and length on later terms must be ignored
    send(32'h0001_0000, 32'h0001_0000, 32'hdead_beef, 8'd0, 1'b0, w1);
    e = cadd(e, cmul(32'h0001_0000, 32'h0001_0000));
    send(32'h0001_0000, 32'h0001_0000, 32'h1234_5678, 8'd5, 1'b0, w2);
    e = cadd(e, cmul(32'h0001_0000, 32'h0001_0000));
    exp_q.push_back(e);
    n_total++; if (res_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_capture_cycle: got valid=%b busy=%b want valid=0 busy=1", res_valid, busy);
    else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (res_valid !== 1'b1 || res_data !== 32'h0004_0002)
      $display("FAIL single_result: got valid=%b data=%h want valid=1 data=00040002", res_valid, res_data);
    else n_pass++;
    n_total++; if (w0 != 0 || w1 != 0 || w2 != 0)
      $display("FAIL single_waits: got %0d,%0d,%0d want 0,0,0", w0, w1, w2);
    else n_pass++;
    n_total++; if (ld_q.size() != 3 || ld_q[0] != 1'b1 || ld_q[1] != 1'b0 || ld_q[2] != 1'b0)
      $display("FAIL single_is_load: got %0d steps first=%b want 3 steps pattern 100", ld_q.size(),
               ld_q.size() > 0 ? ld_q[0] : 1'b0);
    else n_pass++;
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL single_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    int w, bad;
    logic [31:0] x, y, b, e;
    ld_q.delete();
    bad = 0;
    for (int v = 0; v < 2; v++) begin
      b = $urandom; e = b;
      for (int t = 0; t < 2; t++) begin
        x = $urandom; y = $urandom;
        send(x, y, b, 8'd1, !(v == 1 && t == 1), w);
        e = cadd(e, cmul(x, y));
        if (w != 0) bad++;
      end
      exp_q.push_back(e);
    end
    n_total++; if (bad != 0) $display("FAIL b2b_stalls: got %0d stalled terms want 0", bad); else n_pass++;
    n_total++; if (ld_q.size() != 4 || ld_q[0] != 1'b1 || ld_q[1] != 1'b0 || ld_q[2] != 1'b1 || ld_q[3] != 1'b0)
      $display("FAIL b2b_is_load: got %0d steps want 4 steps pattern 1010", ld_q.size());
    else n_pass++;
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL b2b_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_len1_stream;
    int w[4];
    logic [31:0] x, y, b;
    for (int v = 0; v < 4; v++) begin
      x = $urandom; y = $urandom; b = $urandom;
      send(x, y, b, 8'd0, v != 3, w[v]);
      exp_q.push_back(cadd(b, cmul(x, y)));
    end
    n_total++; if (w[0] != 0 || w[1] != 1 || w[2] != 1 || w[3] != 1)
      $display("FAIL len1_ready_pattern: got waits %0d,%0d,%0d,%0d want 0,1,1,1", w[0], w[1], w[2], w[3]);
    else n_pass++;
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL len1_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL len1_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure;
    int w, bad;
    logic [31:0] x, y, b, ea, eb;
    res_ready = 1'b0;
    bad = 0;
    x = $urandom; y = $urandom; b = $urandom;
    send(x, y, b, 8'd0, 1'b0, w);
    ea = cadd(b, cmul(x, y));
    exp_q.push_back(ea);
    repeat (3) @(posedge CLK);
    #1;
    n_total++; if (res_valid !== 1'b1 || res_data !== ea)
      $display("FAIL bp_held_first: got valid=%b data=%h want valid=1 data=%h", res_valid, res_data, ea);
    else n_pass++;
    b = $urandom; eb = b;
    for (int t = 0; t < 3; t++) begin
      x = $urandom; y = $urandom;
      send(x, y, b, 8'd3, 1'b1, w);
      eb = cadd(eb, cmul(x, y));
      if (w != 0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL bp_nonlast_stall: got %0d stalled terms want 0", bad); else n_pass++;
    x = $urandom; y = $urandom;
    in_x = x; in_y = y; in_bias = $urandom; in_len_m1 = $urandom;
    eb = cadd(eb, cmul(x, y));
    exp_q.push_back(eb);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++; if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== ea)
        $display("FAIL bp_last_held: got ready=%b valid=%b data=%h want ready=0 valid=1 data=%h",
                 in_ready, res_valid, res_data, ea);
      else n_pass++;
      @(posedge CLK); #1;
    end
    res_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL bp_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stalls;
    int w, bad, en0, sb0;
    logic [31:0] x, y, b, e;
    bad = 0; en0 = en_cnt; sb0 = stall_bad;
    b = $urandom; e = b;
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #1;
      end
      x = $urandom; y = $urandom;
      send(x, y, (t == 0) ? b : $urandom, (t == 0) ? 8'd7 : 8'($urandom), 1'b0, w);
      e = cadd(e, cmul(x, y));
      if (w != 0) bad++;
    end
    exp_q.push_back(e);
    n_total++; if (bad != 0) $display("FAIL stall_waits: got %0d stalled terms want 0", bad); else n_pass++;
    n_total++; if (en_cnt - en0 != 8) $display("FAIL stall_enables: got %0d want 8", en_cnt - en0); else n_pass++;
    n_total++; if (stall_bad != sb0) $display("FAIL stall_spurious_enable: got %0d want 0", stall_bad - sb0); else n_pass++;
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL stall_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap;
    int w, bad, loads;
    logic [31:0] x, y, b, e;
    ld_q.delete();
    bad = 0; loads = 0;
    b = $urandom; e = b;
    for (int t = 0; t < 256; t++) begin
      x = $urandom; y = $urandom;
      send(x, y, b, 8'd255, t != 255, w);
      e = cadd(e, cmul(x, y));
      if (w != 0) bad++;
    end
    exp_q.push_back(e);
    foreach (ld_q[i]) if (ld_q[i]) loads++;
    n_total++; if (bad != 0) $display("FAIL wrap_waits: got %0d stalled terms want 0", bad); else n_pass++;
    n_total++; if (ld_q.size() != 256 || loads != 1)
      $display("FAIL wrap_steps: got %0d steps %0d loads want 256 steps 1 load", ld_q.size(), loads);
    else n_pass++;
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL wrap_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset;
    int w;
    logic [31:0] x, y, b, e;
    for (int t = 0; t < 2; t++) send($urandom, $urandom, 32'h5555_aaaa, 8'd3, 1'b1, w);
    in_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    n_total++; if (res_valid !== 1'b0 || res_data !== 32'h0)
      $display("FAIL arst_result: got valid=%b data=%h want valid=0 data=0", res_valid, res_data);
    else n_pass++;
    n_total++; if (busy !== 1'b0 || mac_enable !== 1'b0 || mac_is_load !== 1'b0)
      $display("FAIL arst_ctrl: got busy=%b en=%b load=%b want 0,0,0", busy, mac_enable, mac_is_load);
    else n_pass++;
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_busy_after: got %b want 0", busy); else n_pass++;
    b = $urandom; e = b;
    for (int t = 0; t < 2; t++) begin
      x = $urandom; y = $urandom;
      send(x, y, b, 8'd1, t == 0, w);
      e = cadd(e, cmul(x, y));
    end
    exp_q.push_back(e);
    repeat (4) @(posedge CLK);
    #1;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL arst_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [31:0] ee, oo;
      ee = exp_q.pop_front(); oo = obs_q.pop_front();
      n_total++; if (oo !== ee) $display("FAIL arst_sb: got %h want %h", oo, ee); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_len1_stream();
    test_backpressure();
    test_stalls();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
